// File: rtl/sdram_pkg.sv
//------------------------------------------------------------------------------
// sdram_pkg : shared SDRAM controller types, state encoding and commands.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

package sdram_pkg;

    typedef enum logic [4:0] {
        ST_INIT  = 5'b00001,
        ST_ARBIT = 5'b00010,
        ST_AREF  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_READ  = 5'b10000
    } state_e;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_AREF      = 4'b0001;
    localparam logic [3:0] CMD_MODE      = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;

    // Identity of the last data engine served (round-robin tie break)
    localparam logic LAST_WR = 1'b0;
    localparam logic LAST_RD = 1'b1;

    typedef struct packed {
        logic ref_g;
        logic wr_g;
        logic rd_g;
    } grant_t;

endpackage

`default_nettype wire

// File: rtl/sdram_arbit_pick.sv
//------------------------------------------------------------------------------
// sdram_arbit_pick : combinational next-grant selection (refresh first, then
// write/read by fixed priority or round robin via the last input).
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_arbit_pick
    import sdram_pkg::*;
(
    input  logic   ref_req,
    input  logic   wr_req,
    input  logic   rd_req,
    input  logic   last,
    output grant_t grant
);

    always_comb begin
        grant = '0;
        if (ref_req) begin
            grant.ref_g = 1'b1;
        end else if (wr_req && rd_req) begin
            // Tie: serve whichever data engine did not go last
            if (last == LAST_RD) begin
                grant.wr_g = 1'b1;
            end else begin
                grant.rd_g = 1'b1;
            end
        end else if (wr_req) begin
            grant.wr_g = 1'b1;
        end else if (rd_req) begin
            grant.rd_g = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_arbit.sv
//------------------------------------------------------------------------------
// sdram_arbit : SDRAM command bus sequencer sharing the pins between the init,
// refresh, write and read engines. Macro ARBIT_RR_EN enables write/read RR.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int CMD_W  = 4,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_init_end,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              ref_req,
    input  logic              flag_ref_end,
    input  logic [CMD_W-1:0]  aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              flag_wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic              rd_req,
    input  logic              flag_rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_ba,
    output logic              ref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic [CMD_W-1:0]  sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba
);

    state_e state_q, state_d;
    logic   ref_en_q, ref_en_d;
    logic   wr_en_q, wr_en_d;
    logic   rd_en_q, rd_en_d;
    logic   last;
    grant_t pick;

    sdram_arbit_pick u_pick (
        .ref_req (ref_req),
        .wr_req  (wr_req),
        .rd_req  (rd_req),
        .last    (last),
        .grant   (pick)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT:  if (flag_init_end) state_d = ST_ARBIT;
            ST_ARBIT: begin
                if (pick.ref_g)     state_d = ST_AREF;
                else if (pick.wr_g) state_d = ST_WRITE;
                else if (pick.rd_g) state_d = ST_READ;
            end
            ST_AREF:  if (flag_ref_end) state_d = ST_ARBIT;
            ST_WRITE: if (flag_wr_end)  state_d = ST_ARBIT;
            ST_READ:  if (flag_rd_end)  state_d = ST_ARBIT;
            default:  state_d = ST_INIT;
        endcase
    end

    // Grant states are only entered from ARBIT, so this marks the first cycle
    always_comb begin
        ref_en_d = (state_q == ST_ARBIT) && (state_d == ST_AREF);
        wr_en_d  = (state_q == ST_ARBIT) && (state_d == ST_WRITE);
        rd_en_d  = (state_q == ST_ARBIT) && (state_d == ST_READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            ref_en_q <= 1'b0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_en_q <= ref_en_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
        end
    end

`ifdef ARBIT_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (wr_en_d)      last_d = LAST_WR;
        else if (rd_en_d) last_d = LAST_RD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= LAST_RD;
        end else begin
            last_q <= last_d;
        end
    end

    assign last = last_q;
`else
    // Permanently "read went last" reduces the pick to fixed write-over-read
    assign last = LAST_RD;
`endif

    assign ref_en = ref_en_q;
    assign wr_en  = wr_en_q;
    assign rd_en  = rd_en_q;

    always_comb begin
        sdram_cmd  = CMD_W'(CMD_NOP);
        sdram_addr = '0;
        sdram_ba   = '0;
        unique case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_ba   = wr_ba;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_ba   = rd_ba;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbit.sv
//------------------------------------------------------------------------------
// tb_sdram_arbit : directed scenarios plus random traffic against an
// owner/age model of the bus arbiter.
// Rev 1.0 : initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sdram_arbit;

    localparam int CMD_W  = 4;
    localparam int ADDR_W = 13;
    localparam int BA_W   = 2;

    localparam int O_INIT = 0;
    localparam int O_IDLE = 1;
    localparam int O_REF  = 2;
    localparam int O_WR   = 3;
    localparam int O_RD   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flag_init_end = 1'b0;
    logic [CMD_W-1:0]  init_cmd = '0;
    logic [ADDR_W-1:0] init_addr = '0;
    logic              ref_req = 1'b0;
    logic              flag_ref_end = 1'b0;
    logic [CMD_W-1:0]  aref_cmd = '0;
    logic [ADDR_W-1:0] aref_addr = '0;
    logic              wr_req = 1'b0;
    logic              flag_wr_end = 1'b0;
    logic [CMD_W-1:0]  wr_cmd = '0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [BA_W-1:0]   wr_ba = '0;
    logic              rd_req = 1'b0;
    logic              flag_rd_end = 1'b0;
    logic [CMD_W-1:0]  rd_cmd = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [BA_W-1:0]   rd_ba = '0;
    logic              ref_en, wr_en, rd_en;
    logic [CMD_W-1:0]  sdram_cmd;
    logic [ADDR_W-1:0] sdram_addr;
    logic [BA_W-1:0]   sdram_ba;

    sdram_arbit #(.CMD_W(CMD_W), .ADDR_W(ADDR_W), .BA_W(BA_W)) dut (
        .clk(clk), .rst_n(rst_n), .flag_init_end(flag_init_end),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .ref_req(ref_req), .flag_ref_end(flag_ref_end),
        .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .flag_wr_end(flag_wr_end),
        .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_ba(wr_ba),
        .rd_req(rd_req), .flag_rd_end(flag_rd_end),
        .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_ba(rd_ba),
        .ref_en(ref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Model: who owns the bus and for how many cycles it has owned it
    int m_owner   = O_INIT;
    int m_age     = 1;
    bit m_last_rd = 1'b1;
    int m_nxt;

    function automatic int choose(input bit r, input bit w, input bit d, input bit last_rd);
        if (r) return O_REF;
`ifdef ARBIT_RR_EN
        if (w && d) return last_rd ? O_WR : O_RD;
`endif
        if (w) return O_WR;
        if (d) return O_RD;
        return O_IDLE;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner   = O_INIT;
            m_age     = 1;
            m_last_rd = 1'b1;
        end else begin
            m_nxt = m_owner;
            case (m_owner)
                O_INIT: if (flag_init_end) m_nxt = O_IDLE;
                O_IDLE: m_nxt = choose(ref_req, wr_req, rd_req, m_last_rd);
                O_REF:  if (flag_ref_end) m_nxt = O_IDLE;
                O_WR:   if (flag_wr_end)  m_nxt = O_IDLE;
                default: if (flag_rd_end) m_nxt = O_IDLE;
            endcase
            if (m_nxt != m_owner) begin
                m_owner = m_nxt;
                m_age   = 0;
                if (m_nxt == O_WR) m_last_rd = 1'b0;
                if (m_nxt == O_RD) m_last_rd = 1'b1;
            end else begin
                m_age++;
            end
        end
    end

    logic [CMD_W-1:0]  e_cmd;
    logic [ADDR_W-1:0] e_addr;
    logic [BA_W-1:0]   e_ba;

    always @(posedge clk) begin
        #1;
        e_cmd = 4'b0111; e_addr = '0; e_ba = '0;
        case (m_owner)
            O_INIT: begin e_cmd = init_cmd; e_addr = init_addr; end
            O_REF:  begin e_cmd = aref_cmd; e_addr = aref_addr; end
            O_WR:   begin e_cmd = wr_cmd; e_addr = wr_addr; e_ba = wr_ba; end
            O_RD:   begin e_cmd = rd_cmd; e_addr = rd_addr; e_ba = rd_ba; end
            default: ;
        endcase
        check("cyc_cmd",  sdram_cmd,  e_cmd);
        check("cyc_addr", sdram_addr, e_addr);
        check("cyc_ba",   sdram_ba,   e_ba);
        check("cyc_ref_en", ref_en, (m_owner == O_REF) && (m_age == 0));
        check("cyc_wr_en",  wr_en,  (m_owner == O_WR)  && (m_age == 0));
        check("cyc_rd_en",  rd_en,  (m_owner == O_RD)  && (m_age == 0));
    end

    int who, waited, exp_who;

    initial begin
        init_cmd = 4'b0010; init_addr = 13'h0400;
        repeat (2) @(negedge clk);
        check("rst_cmd", sdram_cmd, 4'b0010);
        check("rst_ba", sdram_ba, 2'b00);
        check("rst_grants", {ref_en, wr_en, rd_en}, 3'b000);
        rst_n = 1'b1;
        @(negedge clk);
        check("init_follow", sdram_addr, 13'h0400);
        flag_init_end = 1'b1;
        @(negedge clk);
        flag_init_end = 1'b0;
        check("arbit_nop_cmd", sdram_cmd, 4'b0111);
        check("arbit_nop_addr", sdram_addr, 13'h0000);
        check("arbit_grants", {ref_en, wr_en, rd_en}, 3'b000);

        // Refresh alone
        ref_req = 1'b1; aref_cmd = 4'b0010; aref_addr = 13'h0400;
        @(negedge clk);
        ref_req = 1'b0;
        check("ref_en_pulse", ref_en, 1'b1);
        check("ref_bus_cmd", sdram_cmd, 4'b0010);
        check("ref_bus_addr", sdram_addr, 13'h0400);
        @(negedge clk);
        check("ref_en_once", ref_en, 1'b0);
        flag_ref_end = 1'b1;
        @(negedge clk);
        flag_ref_end = 1'b0;
        check("ref_back_nop", sdram_cmd, 4'b0111);

        // Refresh and write on the same edge
        ref_req = 1'b1; wr_req = 1'b1;
        wr_cmd = 4'b0011; wr_addr = 13'h1abc; wr_ba = 2'b10;
        @(negedge clk);
        ref_req = 1'b0;
        check("rw_ref_first", {ref_en, wr_en}, 2'b10);
        flag_ref_end = 1'b1;
        @(negedge clk);
        flag_ref_end = 1'b0;
        check("rw_gap_nop", {sdram_cmd, wr_en}, {4'b0111, 1'b0});
        @(negedge clk);
        check("rw_wr_en", wr_en, 1'b1);
        check("rw_wr_ba", sdram_ba, 2'b10);
        check("rw_wr_addr", sdram_addr, 13'h1abc);

        // Foreign end flag during WRITE
        flag_rd_end = 1'b1;
        @(negedge clk);
        flag_rd_end = 1'b0;
        check("wr_ignore_rd_end", sdram_cmd, 4'b0011);
        flag_wr_end = 1'b1;
        @(negedge clk);
        flag_wr_end = 1'b0;
        check("wr_end_nop", sdram_cmd, 4'b0111);

        // Both data requests held high; the last served engine was write
        rd_req = 1'b1; rd_cmd = 4'b0101; rd_addr = 13'h0123; rd_ba = 2'b11;
        for (int g = 0; g < 4; g++) begin
            who = 0; waited = 0;
            while (who == 0 && waited < 10) begin
                @(negedge clk);
                waited++;
                if (wr_en) who = 1;
                else if (rd_en) who = 2;
                else if (ref_en) who = 3;
            end
`ifdef ARBIT_RR_EN
            exp_who = (g % 2 == 0) ? 2 : 1;
`else
            exp_who = 1;
`endif
            check("wr_rd_sequence", who, exp_who);
            if (who == 1) flag_wr_end = 1'b1;
            else if (who == 2) flag_rd_end = 1'b1;
            else if (who == 3) flag_ref_end = 1'b1;
            @(negedge clk);
            flag_wr_end = 1'b0; flag_rd_end = 1'b0; flag_ref_end = 1'b0;
        end

        // Reset in the middle of a read grant
        wr_req = 1'b0;
        init_cmd = 4'b0000; init_addr = 13'h0055;
        who = 0; waited = 0;
        while (who == 0 && waited < 10) begin
            @(negedge clk);
            waited++;
            if (rd_en) who = 2;
        end
        check("mid_read_grant", who, 2);
        @(negedge clk);
        check("mid_read_ba", sdram_ba, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cmd", sdram_cmd, 4'b0000);
        check("async_rst_addr", sdram_addr, 13'h0055);
        check("async_rst_ba", sdram_ba, 2'b00);
        check("async_rst_rd_en", rd_en, 1'b0);
        @(negedge clk);
        rd_req = 1'b0;
        rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst_n         = ($urandom_range(0, 399) != 0);
            flag_init_end = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) ref_req = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) wr_req  = $urandom_range(0, 1);
            if ($urandom_range(0, 3) == 0) rd_req  = $urandom_range(0, 1);
            flag_ref_end = ($urandom_range(0, 5) == 0);
            flag_wr_end  = ($urandom_range(0, 5) == 0);
            flag_rd_end  = ($urandom_range(0, 5) == 0);
            init_cmd  = CMD_W'($urandom);  init_addr = ADDR_W'($urandom);
            aref_cmd  = CMD_W'($urandom);  aref_addr = ADDR_W'($urandom);
            wr_cmd    = CMD_W'($urandom);  wr_addr   = ADDR_W'($urandom);
            wr_ba     = BA_W'($urandom);
            rd_cmd    = CMD_W'($urandom);  rd_addr   = ADDR_W'($urandom);
            rd_ba     = BA_W'($urandom);
        end
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
